// File: rtl/postadder_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : postadder_sequencer
//  Brief    : Instruction-driven controller for the three-accumulator
//             post-adder. Buffers packed control words in a small FIFO,
//             issues each word for rpt+1 non-stalled cycles on registered
//             mode/addr/outsel outputs, and flags captured results with a
//             dout_valid pulse aligned to the post-adder's registered dout.
//  Revision : 1.0 - initial release
// ============================================================================
module postadder_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int RPT_W      = 4,
    parameter int OUT_LAT    = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [16+RPT_W-1:0] instr_data,
    input  logic                stall,
    input  logic                flush,
    output logic [2:0]          mode1,
    output logic [2:0]          mode2,
    output logic [2:0]          mode3,
    output logic [1:0]          addr2,
    output logic [1:0]          addr3,
    output logic [1:0]          outsel,
    output logic                dout_valid,
    output logic                busy
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int              c_AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              c_DW   = 16 + RPT_W;
    localparam logic [c_AW:0]   c_FULL = FIFO_DEPTH[c_AW:0];

    // Word field positions (control fields occupy [14:0], capture flag [15])
    localparam int              c_CAP_BIT = 15;

    // ------------------------------------------------------------------------
    // State machine encoding: IDLE has no active word, ISSUE holds one
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // FIFO storage and bookkeeping
    logic [c_DW-1:0]    r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [c_DW-1:0]    w_head;

    // Active word and its remaining repeat count
    logic [15:0]        r_active;
    logic [RPT_W-1:0]   r_rpt_cnt;

    // Issue decisions for the coming edge
    logic               w_issue;
    logic               w_final;

    // Registered control outputs
    logic [2:0]         r_mode1;
    logic [2:0]         r_mode2;
    logic [2:0]         r_mode3;
    logic [1:0]         r_addr2;
    logic [1:0]         r_addr3;
    logic [1:0]         r_outsel;
    logic               r_issuing;
    logic               r_cap_flag;
    logic [OUT_LAT-1:0] r_pipe;

    // ------------------------------------------------------------------------
    // FIFO status and handshake; flush swallows a same-cycle push
    // ------------------------------------------------------------------------
    assign w_full      = (r_count == c_FULL);
    assign w_empty     = (r_count == '0);
    assign instr_ready = ~w_full;
    assign w_push      = instr_valid & ~w_full & ~flush;
    assign w_head      = r_mem[r_rd_ptr];

    // Storage array: written on accepted pushes, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= instr_data;
        end
    end

    // Pointer and occupancy tracking; flush empties the queue outright
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, pop and issue decisions; flush overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_final     = 1'b0;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty && !stall) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        w_issue = 1'b1;
                        if (r_rpt_cnt == '0) begin
                            // Last repeat: chain straight into the next word
                            // when one is waiting so there is no bubble.
                            w_final = 1'b1;
                            if (!w_empty) begin
                                w_pop = 1'b1;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Active word register and repeat counter (frozen while stalled)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_active  <= '0;
            r_rpt_cnt <= '0;
        end else if (flush) begin
            r_rpt_cnt <= '0;
        end else if (w_pop) begin
            r_active  <= w_head[15:0];
            r_rpt_cnt <= w_head[c_DW-1:16];
        end else if (w_issue && !w_final) begin
            r_rpt_cnt <= r_rpt_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registered post-adder controls: word fields on issue cycles, NOP modes
    // otherwise; addresses and outsel keep their last issued values.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode1    <= 3'b000;
            r_mode2    <= 3'b000;
            r_mode3    <= 3'b000;
            r_addr2    <= 2'b00;
            r_addr3    <= 2'b00;
            r_outsel   <= 2'b00;
            r_issuing  <= 1'b0;
            r_cap_flag <= 1'b0;
        end else begin
            r_issuing  <= w_issue;
            // Marks the cycle showing a capture word's final repeat
            r_cap_flag <= w_final & r_active[c_CAP_BIT];
            if (w_issue) begin
                r_mode1  <= r_active[2:0];
                r_mode2  <= r_active[5:3];
                r_mode3  <= r_active[8:6];
                r_addr2  <= r_active[10:9];
                r_addr3  <= r_active[12:11];
                r_outsel <= r_active[14:13];
            end else begin
                r_mode1  <= 3'b000;
                r_mode2  <= 3'b000;
                r_mode3  <= 3'b000;
            end
        end
    end

    // ------------------------------------------------------------------------
    // dout_valid delay line: the capture marker enters at the end of the
    // final issue cycle and emerges OUT_LAT cycles later.
    // ------------------------------------------------------------------------
    generate
        if (OUT_LAT == 1) begin : g_pipe_single
            // Single-stage delay line
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_pipe <= '0;
                end else if (flush) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= r_cap_flag;
                end
            end
        end else begin : g_pipe_multi
            // Multi-stage shift register, keeps shifting through stalls
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_pipe <= '0;
                end else if (flush) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[OUT_LAT-2:0], r_cap_flag};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign mode1      = r_mode1;
    assign mode2      = r_mode2;
    assign mode3      = r_mode3;
    assign addr2      = r_addr2;
    assign addr3      = r_addr3;
    assign outsel     = r_outsel;
    assign dout_valid = r_pipe[OUT_LAT-1];

    // Busy covers queued words, the active word, a word showing on the
    // outputs, and any capture still travelling toward dout.
    assign busy = ~w_empty | (r_state == S_ISSUE) | r_issuing | r_cap_flag | (|r_pipe);

endmodule
`default_nettype wire

// File: tb/tb_postadder_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_postadder_sequencer
//  Brief    : Scoreboard bench for postadder_sequencer. Accepted words are
//             expanded into expected issue records; a monitor compares every
//             output cycle and tracks expected dout_valid cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_postadder_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int RPT_W      = 4;
    localparam int OUT_LAT    = 1;
    localparam int DW         = 16 + RPT_W;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [DW-1:0] instr_data = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [2:0]    mode1, mode2, mode3;
    logic [1:0]    addr2, addr3, outsel;
    logic          dout_valid;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit e_stall = 1'b0;
    bit e_flush = 1'b0;

    typedef struct {
        logic [14:0] f;
        bit          cap;
    } issue_t;

    issue_t iss_q[$];
    int     cap_q[$];

    always #5 clk = ~clk;

    postadder_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RPT_W      (RPT_W),
        .OUT_LAT    (OUT_LAT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .stall       (stall),
        .flush       (flush),
        .mode1       (mode1),
        .mode2       (mode2),
        .mode3       (mode3),
        .addr2       (addr2),
        .addr3       (addr3),
        .outsel      (outsel),
        .dout_valid  (dout_valid),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [2:0] m1, input logic [2:0] m2,
                                         input logic [2:0] m3, input logic [1:0] a2,
                                         input logic [1:0] a3, input logic [1:0] os,
                                         input logic cap, input logic [RPT_W-1:0] rpt);
        return {rpt, cap, os, a3, a2, m3, m2, m1};
    endfunction

    // Random word: mode1 never NOP so every issue cycle is visible
    function automatic logic [DW-1:0] rand_word();
        logic [RPT_W-1:0] rpt;
        rpt = ($urandom_range(0, 9) == 0) ? {RPT_W{1'b1}} : RPT_W'($urandom_range(0, 3));
        return mk(3'($urandom_range(1, 7)), 3'($urandom), 3'($urandom),
                  2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), rpt);
    endfunction

    // Scoreboard: expand each accepted word into rpt+1 expected issue records
    always @(posedge clk) begin
        cyc++;
        e_stall = stall;
        e_flush = flush;
        if (rstn) begin
            if (flush) begin
                iss_q.delete();
                cap_q.delete();
            end else if (instr_valid && instr_ready) begin
                for (int r = 0; r <= int'(instr_data[DW-1:16]); r++) begin
                    issue_t e;
                    e.f   = instr_data[14:0];
                    e.cap = instr_data[15] && (r == int'(instr_data[DW-1:16]));
                    iss_q.push_back(e);
                end
            end
        end
    end

    // Reset discards everything in flight
    always @(negedge rstn) begin
        iss_q.delete();
        cap_q.delete();
    end

    // Monitor: compare each visible issue cycle and every dout_valid cycle
    always @(negedge clk) begin
        issue_t e;
        bit     exp_dv;
        if (rstn) begin
            if (e_stall || e_flush) begin
                check("nop_after_stall_or_flush", {mode1, mode2, mode3}, 0);
            end
            if ((mode1 | mode2 | mode3) != 3'b000) begin
                if (iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got fields %0h expected none (cycle %0d)",
                             {outsel, addr3, addr2, mode3, mode2, mode1}, cyc);
                end else begin
                    e = iss_q.pop_front();
                    check("issue_fields", {outsel, addr3, addr2, mode3, mode2, mode1}, e.f);
                    if (e.cap) cap_q.push_back(cyc + OUT_LAT);
                end
            end
            exp_dv = (cap_q.size() > 0) && (cap_q[0] == cyc);
            check("dout_valid", dout_valid, exp_dv);
            if (exp_dv) void'(cap_q.pop_front());
        end
    end

    task automatic push_word(input logic [DW-1:0] w);
        instr_data  = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic expect_cycle(input string name, input logic [2:0] m1, input logic [2:0] m2,
                                input logic [2:0] m3, input logic dv, input logic b);
        @(negedge clk);
        check(name, {mode1, mode2, mode3, dout_valid, busy}, {m1, m2, m3, dv, b});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        check(name, busy, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        check("reset_state", {instr_ready, busy, dout_valid, mode1, mode2, mode3, addr2, addr3, outsel},
              {1'b1, 17'b0});

        // Single capture word: outputs two edges after acceptance
        push_word(mk(3'b010, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0));
        expect_cycle("t1_accepted", 0, 0, 0, 0, 1);
        expect_cycle("t1_popped",   0, 0, 0, 0, 1);
        expect_cycle("t1_issue",    3'b010, 0, 0, 0, 1);
        expect_cycle("t1_dout",     0, 0, 0, 1, 1);
        expect_cycle("t1_idle",     0, 0, 0, 0, 0);

        // Repeat then back-to-back capture word
        push_word(mk(3'b000, 3'b001, 3'b000, 2'd2, 2'd0, 2'd0, 1'b0, 4'd3));
        push_word(mk(3'b000, 3'b010, 3'b000, 2'd2, 2'd0, 2'd1, 1'b1, 4'd0));
        expect_cycle("t2_popped", 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) expect_cycle("t2_repeat", 0, 3'b001, 0, 0, 1);
        expect_cycle("t2_second", 0, 3'b010, 0, 0, 1);
        expect_cycle("t2_dout",   0, 0, 0, 1, 1);
        expect_cycle("t2_idle",   0, 0, 0, 0, 0);
        check("t2_idle_holds_addr", {addr2, outsel}, {2'd2, 2'd1});

        // Stall for two cycles during an rpt=2 capture word
        push_word(mk(3'b011, 3'b000, 3'b000, 2'd1, 2'd1, 2'd2, 1'b1, 4'd2));
        expect_cycle("t3_accepted", 0, 0, 0, 0, 1);
        expect_cycle("t3_popped",   0, 0, 0, 0, 1);
        expect_cycle("t3_issue1",   3'b011, 0, 0, 0, 1);
        stall = 1'b1;
        expect_cycle("t3_stall1",   0, 0, 0, 0, 1);
        check("t3_stall_holds_addr", {addr2, addr3, outsel}, {2'd1, 2'd1, 2'd2});
        expect_cycle("t3_stall2",   0, 0, 0, 0, 1);
        stall = 1'b0;
        expect_cycle("t3_issue2",   3'b011, 0, 0, 0, 1);
        expect_cycle("t3_issue3",   3'b011, 0, 0, 0, 1);
        expect_cycle("t3_dout",     0, 0, 0, 1, 1);
        expect_cycle("t3_idle",     0, 0, 0, 0, 0);

        // FIFO full under stall, then release
        stall = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) push_word(rand_word());
        @(negedge clk);
        check("t4_full_ready", instr_ready, 1'b0);
        instr_data  = rand_word();
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_blocked_ready", instr_ready, 1'b0);
        end
        stall = 1'b0;
        @(negedge clk);
        check("t4_ready_after_pop", instr_ready, 1'b1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        drain("t4_drain");

        // Flush during the second repeat with two words queued
        push_word(mk(3'b101, 3'b000, 3'b000, 2'd3, 2'd0, 2'd0, 1'b1, 4'd3));
        push_word(rand_word());
        push_word(rand_word());
        expect_cycle("t5_rep1", 3'b101, 0, 0, 0, 1);
        expect_cycle("t5_rep2", 3'b101, 0, 0, 0, 1);
        flush       = 1'b1;
        instr_data  = rand_word();
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        instr_valid = 1'b0;
        expect_cycle("t5_after_flush", 0, 0, 0, 0, 0);
        check("t5_ready", instr_ready, 1'b1);
        for (int i = 0; i < 6; i++) expect_cycle("t5_quiet", 0, 0, 0, 0, 0);

        // Asynchronous reset mid-issue
        push_word(mk(3'b110, 3'b000, 3'b000, 2'd1, 2'd2, 2'd3, 1'b1, 4'd5));
        expect_cycle("t6_accepted", 0, 0, 0, 0, 1);
        expect_cycle("t6_popped",   0, 0, 0, 0, 1);
        expect_cycle("t6_issue",    3'b110, 0, 0, 0, 1);
        #2 rstn = 1'b0;
        #1;
        check("t6_async_reset", {instr_ready, busy, dout_valid, mode1, mode2, mode3, addr2, addr3, outsel},
              {1'b1, 17'b0});
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;

        // All-ones repeat count after reset: 2^RPT_W issue cycles
        push_word(mk(3'b111, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 1'b1, {RPT_W{1'b1}}));
        expect_cycle("t7_accepted", 0, 0, 0, 0, 1);
        expect_cycle("t7_popped",   0, 0, 0, 0, 1);
        for (int i = 0; i < (1 << RPT_W); i++) expect_cycle("t7_issue", 3'b111, 0, 0, 0, 1);
        expect_cycle("t7_dout", 0, 0, 0, 1, 1);
        expect_cycle("t7_idle", 0, 0, 0, 0, 0);

        // Randomized traffic with stalls and occasional flushes
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            instr_valid = ($urandom_range(0, 1) == 1);
            instr_data  = rand_word();
            stall       = ($urandom_range(0, 4) == 0);
            flush       = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        drain("random_drain");
        repeat (3) @(negedge clk);
        check("issue_queue_empty", iss_q.size(), 0);
        check("capture_queue_empty", cap_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
